// File: rtl/simple_byte.sv
// -----------------------------------------------------------------------------
// simple_byte
//   Byte-arithmetic execution unit of the SPU even pipeline. Executes the
//   RR-format byte instructions cntb, avgb, absdb and sumb on 128-bit operands
//   with a fixed three-cycle latency (stages S1 -> S2 -> S3). The S3 registers
//   drive the write-back / forwarding outputs. RAW hazards against the
//   in-flight destinations are flagged for both issue slots.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   op[0:10], format[2:0]   decoded opcode and instruction format (0 = RR)
//   rt_addr[0:6]            destination register
//   ra, rb [0:127]          source operands, byte k = bits 8k..8k+7 (byte 0 MSB)
//   imm[0:17]               immediate, not used by these instructions
//   reg_write               instruction writes the register file
//   branch_taken            squash the instruction presented this cycle
//   r{a,b,c}_{even,odd}_addr[0:7], is_r{a,b,c}_{even,odd}_valid
//                           issue-slot source addresses and source-used flags
//   rt_wb[0:127], rt_addr_wb[6:0], reg_write_wb
//                           S3 result, destination and write enable
//   stall_even_raw, stall_odd_raw
//                           combinational RAW hazard flags per issue slot
// -----------------------------------------------------------------------------
module simple_byte (
  input  logic           clk,
  input  logic           reset,
  input  logic [0:10]    op,
  input  logic [2:0]     format,
  input  logic [0:6]     rt_addr,
  input  logic [0:127]   ra,
  input  logic [0:127]   rb,
  input  logic [0:17]    imm,
  input  logic           reg_write,
  input  logic           branch_taken,
  input  logic [0:7]     ra_even_addr,
  input  logic [0:7]     rb_even_addr,
  input  logic [0:7]     rc_even_addr,
  input  logic [0:7]     ra_odd_addr,
  input  logic [0:7]     rb_odd_addr,
  input  logic [0:7]     rc_odd_addr,
  input  logic           is_ra_even_valid,
  input  logic           is_rb_even_valid,
  input  logic           is_rc_even_valid,
  input  logic           is_ra_odd_valid,
  input  logic           is_rb_odd_valid,
  input  logic           is_rc_odd_valid,
  output logic [0:127]   rt_wb,
  output logic [6:0]     rt_addr_wb,
  output logic           reg_write_wb,
  output logic           stall_even_raw,
  output logic           stall_odd_raw
);

  localparam logic [0:10] OP_CNTB  = 11'b01010110100;
  localparam logic [0:10] OP_AVGB  = 11'b00011010011;
  localparam logic [0:10] OP_ABSDB = 11'b00001010011;
  localparam logic [0:10] OP_SUMB  = 11'b01001010011;
  localparam logic [2:0]  FMT_RR   = 3'd0;

  // ---------------------------------------------------------------------------
  // Byte helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] popcount8(input logic [7:0] b);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {7'd0, b[i]};
    end
    return cnt;
  endfunction

  // Rounding average, carried in 9 bits so 0xFF + 0xFF + 1 cannot wrap.
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  function automatic logic [7:0] absd8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    if (b >= a) begin
      d = b - a;
    end else begin
      d = a - b;
    end
    return d;
  endfunction

  function automatic logic [15:0] sum4(input logic [31:0] w);
    return {8'd0, w[31:24]} + {8'd0, w[23:16]} + {8'd0, w[15:8]} + {8'd0, w[7:0]};
  endfunction

  // One source operand against one in-flight destination; bit 7 of the
  // source address is compared against a forced 0, so addresses >= 128
  // never match.
  function automatic logic src_hit(input logic       used,
                                   input logic [7:0] src,
                                   input logic       wr,
                                   input logic [6:0] dst);
    return used & wr & (src == {1'b0, dst});
  endfunction

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [0:127] s1_data_r, s2_data_r;
  logic [6:0]   s1_addr_r, s2_addr_r;
  logic         s1_wr_r,   s2_wr_r;

  logic         op_known_s;
  logic         live_s;
  logic [0:127] result_s;
  logic [0:127] s1_data_s;
  logic [6:0]   s1_addr_s;

  // Opcode decode: flags whether op is one of the four byte instructions.
  always_comb begin
    op_known_s = 1'b0;
    case (op)
      OP_CNTB:  op_known_s = 1'b1;
      OP_AVGB:  op_known_s = 1'b1;
      OP_ABSDB: op_known_s = 1'b1;
      OP_SUMB:  op_known_s = 1'b1;
      default:  op_known_s = 1'b0;
    endcase
  end

  // Liveness of the instruction presented this cycle.
  always_comb begin
    live_s = 1'b0;
    if (reg_write && (format == FMT_RR) && op_known_s && !branch_taken) begin
      live_s = 1'b1;
    end else begin
      live_s = 1'b0;
    end
  end

  // Byte-lane datapath: the full result is formed before the S1 register.
  always_comb begin
    result_s = 128'd0;
    case (op)
      OP_CNTB: begin
        for (int k = 0; k < 16; k++) begin
          result_s[8*k +: 8] = popcount8(ra[8*k +: 8]);
        end
      end
      OP_AVGB: begin
        for (int k = 0; k < 16; k++) begin
          result_s[8*k +: 8] = avg8(ra[8*k +: 8], rb[8*k +: 8]);
        end
      end
      OP_ABSDB: begin
        for (int k = 0; k < 16; k++) begin
          result_s[8*k +: 8] = absd8(ra[8*k +: 8], rb[8*k +: 8]);
        end
      end
      OP_SUMB: begin
        // Even halfword of each word takes the rb sum, odd halfword the ra sum.
        for (int w = 0; w < 4; w++) begin
          result_s[32*w +: 16]      = sum4(rb[32*w +: 32]);
          result_s[32*w + 16 +: 16] = sum4(ra[32*w +: 32]);
        end
      end
      default: result_s = 128'd0;
    endcase
  end

  // Bubbles enter the pipe fully zeroed, not just with the write bit cleared.
  always_comb begin
    s1_data_s = 128'd0;
    s1_addr_s = 7'd0;
    if (live_s) begin
      s1_data_s = result_s;
      s1_addr_s = rt_addr;
    end else begin
      s1_data_s = 128'd0;
      s1_addr_s = 7'd0;
    end
  end

  // S1 -> S2 -> S3 pipeline; S3 is the externally visible write-back stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data_r    <= 128'd0;
      s1_addr_r    <= 7'd0;
      s1_wr_r      <= 1'b0;
      s2_data_r    <= 128'd0;
      s2_addr_r    <= 7'd0;
      s2_wr_r      <= 1'b0;
      rt_wb        <= 128'd0;
      rt_addr_wb   <= 7'd0;
      reg_write_wb <= 1'b0;
    end else begin
      s1_data_r    <= s1_data_s;
      s1_addr_r    <= s1_addr_s;
      s1_wr_r      <= live_s;
      s2_data_r    <= s1_data_r;
      s2_addr_r    <= s1_addr_r;
      s2_wr_r      <= s1_wr_r;
      rt_wb        <= s2_data_r;
      rt_addr_wb   <= s2_addr_r;
      reg_write_wb <= s2_wr_r;
    end
  end

  // ---------------------------------------------------------------------------
  // RAW hazard detection against S1, S2 and S3 (current input excluded)
  // ---------------------------------------------------------------------------
  logic even_hit_s;
  logic odd_hit_s;

  // Even-slot sources against every in-flight destination.
  always_comb begin
    even_hit_s = 1'b0;
    even_hit_s = src_hit(is_ra_even_valid, ra_even_addr, s1_wr_r, s1_addr_r)
               | src_hit(is_ra_even_valid, ra_even_addr, s2_wr_r, s2_addr_r)
               | src_hit(is_ra_even_valid, ra_even_addr, reg_write_wb, rt_addr_wb)
               | src_hit(is_rb_even_valid, rb_even_addr, s1_wr_r, s1_addr_r)
               | src_hit(is_rb_even_valid, rb_even_addr, s2_wr_r, s2_addr_r)
               | src_hit(is_rb_even_valid, rb_even_addr, reg_write_wb, rt_addr_wb)
               | src_hit(is_rc_even_valid, rc_even_addr, s1_wr_r, s1_addr_r)
               | src_hit(is_rc_even_valid, rc_even_addr, s2_wr_r, s2_addr_r)
               | src_hit(is_rc_even_valid, rc_even_addr, reg_write_wb, rt_addr_wb);
  end

  // Odd-slot sources against every in-flight destination.
  always_comb begin
    odd_hit_s = 1'b0;
    odd_hit_s = src_hit(is_ra_odd_valid, ra_odd_addr, s1_wr_r, s1_addr_r)
              | src_hit(is_ra_odd_valid, ra_odd_addr, s2_wr_r, s2_addr_r)
              | src_hit(is_ra_odd_valid, ra_odd_addr, reg_write_wb, rt_addr_wb)
              | src_hit(is_rb_odd_valid, rb_odd_addr, s1_wr_r, s1_addr_r)
              | src_hit(is_rb_odd_valid, rb_odd_addr, s2_wr_r, s2_addr_r)
              | src_hit(is_rb_odd_valid, rb_odd_addr, reg_write_wb, rt_addr_wb)
              | src_hit(is_rc_odd_valid, rc_odd_addr, s1_wr_r, s1_addr_r)
              | src_hit(is_rc_odd_valid, rc_odd_addr, s2_wr_r, s2_addr_r)
              | src_hit(is_rc_odd_valid, rc_odd_addr, reg_write_wb, rt_addr_wb);
  end

  // Stall flags are forced low while reset is held.
  always_comb begin
    stall_even_raw = 1'b0;
    stall_odd_raw  = 1'b0;
    if (reset) begin
      stall_even_raw = 1'b0;
      stall_odd_raw  = 1'b0;
    end else begin
      stall_even_raw = even_hit_s;
      stall_odd_raw  = odd_hit_s;
    end
  end

endmodule

// File: tb/tb_simple_byte.sv
// -----------------------------------------------------------------------------
// tb_simple_byte
//   Directed bench for simple_byte. A history of issued instructions, indexed
//   by clock edge, predicts the write-back and hazard outputs; a compare
//   process checks them on every falling edge. Literal expectations in the
//   stimulus pin the model.
// -----------------------------------------------------------------------------
module tb_simple_byte;

  localparam logic [10:0] OP_CNTB  = 11'b01010110100;
  localparam logic [10:0] OP_AVGB  = 11'b00011010011;
  localparam logic [10:0] OP_ABSDB = 11'b00001010011;
  localparam logic [10:0] OP_SUMB  = 11'b01001010011;
  localparam int          HN       = 1024;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [10:0]  op = 11'd0;
  logic [2:0]   format = 3'd0;
  logic [6:0]   rt_addr = 7'd0;
  logic [127:0] ra = 128'd0;
  logic [127:0] rb = 128'd0;
  logic [17:0]  imm = 18'd0;
  logic         reg_write = 1'b0;
  logic         branch_taken = 1'b0;
  logic [7:0]   ra_even_addr = 8'd0, rb_even_addr = 8'd0, rc_even_addr = 8'd0;
  logic [7:0]   ra_odd_addr = 8'd0, rb_odd_addr = 8'd0, rc_odd_addr = 8'd0;
  logic         is_ra_even_valid = 1'b0, is_rb_even_valid = 1'b0, is_rc_even_valid = 1'b0;
  logic         is_ra_odd_valid = 1'b0, is_rb_odd_valid = 1'b0, is_rc_odd_valid = 1'b0;
  logic [127:0] rt_wb;
  logic [6:0]   rt_addr_wb;
  logic         reg_write_wb;
  logic         stall_even_raw;
  logic         stall_odd_raw;

  always #5 clk = ~clk;

  simple_byte dut (
    .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
    .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write), .branch_taken(branch_taken),
    .ra_even_addr(ra_even_addr), .rb_even_addr(rb_even_addr), .rc_even_addr(rc_even_addr),
    .ra_odd_addr(ra_odd_addr), .rb_odd_addr(rb_odd_addr), .rc_odd_addr(rc_odd_addr),
    .is_ra_even_valid(is_ra_even_valid), .is_rb_even_valid(is_rb_even_valid),
    .is_rc_even_valid(is_rc_even_valid), .is_ra_odd_valid(is_ra_odd_valid),
    .is_rb_odd_valid(is_rb_odd_valid), .is_rc_odd_valid(is_rc_odd_valid),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .stall_even_raw(stall_even_raw), .stall_odd_raw(stall_odd_raw)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         wr;
    bit [6:0]   addr;
    bit [127:0] data;
  } rec_t;

  rec_t hist [0:HN-1];
  int   edge_cnt  = 0;
  int   flush_idx = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  function automatic bit [7:0] byte_of(bit [127:0] v, int k);
    return v[127-8*k -: 8];
  endfunction

  // What the instruction should write, straight from the ISA definitions.
  function automatic bit [127:0] isa_result(bit [10:0] o, bit [127:0] a, bit [127:0] b);
    bit [127:0] r;
    int x, y, sa, sb;
    r = 128'd0;
    for (int k = 0; k < 16; k++) begin
      x = byte_of(a, k);
      y = byte_of(b, k);
      if (o == OP_CNTB)  r[127-8*k -: 8] = 8'($countones(byte_of(a, k)));
      if (o == OP_AVGB)  r[127-8*k -: 8] = 8'((x + y + 1) / 2);
      if (o == OP_ABSDB) r[127-8*k -: 8] = 8'((y > x) ? (y - x) : (x - y));
    end
    if (o == OP_SUMB) begin
      for (int w = 0; w < 4; w++) begin
        sa = 0;
        sb = 0;
        for (int j = 0; j < 4; j++) begin
          sa += byte_of(a, 4*w + j);
          sb += byte_of(b, 4*w + j);
        end
        r[127-32*w -: 32] = {16'(sb), 16'(sa)};
      end
    end
    return r;
  endfunction

  function automatic rec_t sample_inputs();
    rec_t r;
    bit known;
    known = (op == OP_CNTB) || (op == OP_AVGB) || (op == OP_ABSDB) || (op == OP_SUMB);
    r.wr   = 1'b0;
    r.addr = 7'd0;
    r.data = 128'd0;
    if (!reset && reg_write && format == 3'd0 && known && !branch_taken) begin
      r.wr   = 1'b1;
      r.addr = rt_addr;
      r.data = isa_result(op, ra, rb);
    end
    return r;
  endfunction

  // Record captured at edge idx; anything captured before the last reset is gone.
  function automatic rec_t at(int idx);
    rec_t z;
    z.wr = 1'b0; z.addr = 7'd0; z.data = 128'd0;
    if (idx < 1 || idx < flush_idx) return z;
    return hist[idx % HN];
  endfunction

  function automatic bit in_flight(bit used, bit [7:0] src);
    bit h;
    h = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rec_t r;
      r = at(edge_cnt - d);
      if (used && r.wr && src == {1'b0, r.addr}) h = 1'b1;
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Capture what the DUT sees at each rising edge.
  always @(posedge clk) begin
    edge_cnt++;
    hist[edge_cnt % HN] = sample_inputs();
  end

  always @(posedge reset) flush_idx = edge_cnt + 1;

  // Per-cycle compare against the history.
  always @(negedge clk) begin
    rec_t e;
    bit se, so;
    if (!done) begin
      e = at(edge_cnt - 2);
      if (reset) begin
        e.wr = 1'b0; e.addr = 7'd0; e.data = 128'd0;
      end
      se = !reset && (in_flight(is_ra_even_valid, ra_even_addr) ||
                      in_flight(is_rb_even_valid, rb_even_addr) ||
                      in_flight(is_rc_even_valid, rc_even_addr));
      so = !reset && (in_flight(is_ra_odd_valid, ra_odd_addr) ||
                      in_flight(is_rb_odd_valid, rb_odd_addr) ||
                      in_flight(is_rc_odd_valid, rc_odd_addr));
      chk("cyc_rt_wb", rt_wb, e.data);
      chk("cyc_rt_addr_wb", {121'd0, rt_addr_wb}, {121'd0, e.addr});
      chk("cyc_reg_write_wb", {127'd0, reg_write_wb}, {127'd0, e.wr});
      chk("cyc_stall_even", {127'd0, stall_even_raw}, {127'd0, se});
      chk("cyc_stall_odd", {127'd0, stall_odd_raw}, {127'd0, so});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] o, input logic [6:0] rt,
                       input logic [127:0] a, input logic [127:0] b,
                       input logic wr, input logic br);
    op = o; rt_addr = rt; ra = a; rb = b; reg_write = wr; branch_taken = br;
  endtask

  task automatic bubble();
    drive(11'd0, 7'd0, 128'd0, 128'd0, 1'b0, 1'b0);
  endtask

  task automatic clear_srcs();
    ra_even_addr = 8'd0; rb_even_addr = 8'd0; rc_even_addr = 8'd0;
    ra_odd_addr = 8'd0; rb_odd_addr = 8'd0; rc_odd_addr = 8'd0;
    is_ra_even_valid = 1'b0; is_rb_even_valid = 1'b0; is_rc_even_valid = 1'b0;
    is_ra_odd_valid = 1'b0; is_rb_odd_valid = 1'b0; is_rc_odd_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_wr", {127'd0, reg_write_wb}, 128'd0);
    chk("rst_data", rt_wb, 128'd0);

    // cntb, 3-cycle latency, result held one cycle
    drive(OP_CNTB, 7'd5, {4{32'hFF00_0F01}}, 128'd0, 1'b1, 1'b0);
    tick();
    bubble();
    chk("cntb_e1_wr", {127'd0, reg_write_wb}, 128'd0);
    tick();
    chk("cntb_e2_wr", {127'd0, reg_write_wb}, 128'd0);
    tick();
    chk("cntb_data", rt_wb, {4{32'h0800_0401}});
    chk("cntb_addr", {121'd0, rt_addr_wb}, 128'd5);
    chk("cntb_wr", {127'd0, reg_write_wb}, 128'd1);
    tick();
    chk("cntb_hold1", {127'd0, reg_write_wb}, 128'd0);

    // avgb, absdb, absdb swapped, back to back
    drive(OP_AVGB, 7'd1, {16{8'hFF}}, {16{8'h01}}, 1'b1, 1'b0);
    tick();
    drive(OP_ABSDB, 7'd2, {16{8'hFF}}, {16{8'h01}}, 1'b1, 1'b0);
    tick();
    drive(OP_ABSDB, 7'd3, {16{8'h01}}, {16{8'hFF}}, 1'b1, 1'b0);
    tick();
    bubble();
    chk("avgb_data", rt_wb, {16{8'h80}});
    tick();
    chk("absdb_data", rt_wb, {16{8'hFE}});
    tick();
    chk("absdb_swap_data", rt_wb, {16{8'hFE}});
    chk("absdb_swap_addr", {121'd0, rt_addr_wb}, 128'd3);

    // sumb
    drive(OP_SUMB, 7'd4, {16{8'hFF}}, {16{8'h01}}, 1'b1, 1'b0);
    tick();
    bubble();
    tick();
    tick();
    chk("sumb_data", rt_wb, {4{32'h0004_03FC}});

    // mixed-value sumb and varied avgb/absdb for the model
    drive(OP_SUMB, 7'd6, 128'h0102_0304_F0E0_D0C0_0000_0000_8080_8080,
          128'hFFFF_0000_1111_2222_7F80_0102_0000_00FF, 1'b1, 1'b0);
    tick();
    drive(OP_AVGB, 7'd8, 128'h00FF_7F80_0102_0304_FEFE_0000_1234_5678,
          128'h00FF_8081_0203_0405_0101_0001_8765_4321, 1'b1, 1'b0);
    tick();
    drive(OP_ABSDB, 7'd10, 128'h00FF_7F80_0102_0304_FEFE_0000_1234_5678,
          128'h00FF_8081_0203_0405_0101_0001_8765_4321, 1'b1, 1'b0);
    tick();

    // back-to-back writes to the same rt
    drive(OP_CNTB, 7'd7, {16{8'h01}}, 128'd0, 1'b1, 1'b0);
    tick();
    drive(OP_CNTB, 7'd7, {16{8'hFF}}, 128'd0, 1'b1, 1'b0);
    tick();
    // non-live variants: wrong format, no write, unknown opcode
    format = 3'd1;
    drive(OP_CNTB, 7'd11, {16{8'hFF}}, 128'd0, 1'b1, 1'b0);
    tick();
    format = 3'd0;
    chk("b2b_first", rt_wb, {16{8'h01}});
    drive(OP_CNTB, 7'd11, {16{8'hFF}}, 128'd0, 1'b0, 1'b0);
    tick();
    chk("b2b_second", rt_wb, {16{8'h08}});
    chk("b2b_addr", {121'd0, rt_addr_wb}, 128'd7);
    drive(11'h7FF, 7'd11, {16{8'hFF}}, 128'd0, 1'b1, 1'b0);
    tick();
    bubble();
    chk("fmt_bubble_wr", {127'd0, reg_write_wb}, 128'd0);
    tick();
    tick();
    tick();

    // hazard: stall for exactly three cycles
    ra_even_addr = 8'd9; is_ra_even_valid = 1'b1;
    drive(OP_CNTB, 7'd9, {16{8'h0F}}, 128'd0, 1'b1, 1'b0);
    #1;
    chk("haz_not_input", {127'd0, stall_even_raw}, 128'd0);
    tick();
    bubble();
    chk("haz_c1", {127'd0, stall_even_raw}, 128'd1);
    tick();
    chk("haz_c2", {127'd0, stall_even_raw}, 128'd1);
    tick();
    chk("haz_c3", {127'd0, stall_even_raw}, 128'd1);
    tick();
    chk("haz_c4", {127'd0, stall_even_raw}, 128'd0);
    drive(OP_CNTB, 7'd9, {16{8'h0F}}, 128'd0, 1'b1, 1'b0);
    tick();
    bubble();
    is_ra_even_valid = 1'b0;
    #1;
    chk("haz_valid_off", {127'd0, stall_even_raw}, 128'd0);
    ra_odd_addr = 8'd9; is_ra_odd_valid = 1'b1;
    #1;
    chk("haz_odd", {127'd0, stall_odd_raw}, 128'd1);
    ra_odd_addr = 8'h89; rc_even_addr = 8'h89; is_rc_even_valid = 1'b1;
    tick();
    chk("haz_msb_odd", {127'd0, stall_odd_raw}, 128'd0);
    chk("haz_msb_even", {127'd0, stall_even_raw}, 128'd0);
    rb_odd_addr = 8'd9; is_rb_odd_valid = 1'b1;
    tick();
    clear_srcs();
    tick();

    // squash: absdb killed, following avgb completes on schedule
    ra_even_addr = 8'd12; is_ra_even_valid = 1'b1;
    drive(OP_ABSDB, 7'd12, {16{8'hFF}}, {16{8'h01}}, 1'b1, 1'b1);
    tick();
    drive(OP_AVGB, 7'd13, {16{8'hFF}}, {16{8'h01}}, 1'b1, 1'b0);
    chk("sq_no_stall", {127'd0, stall_even_raw}, 128'd0);
    tick();
    bubble();
    tick();
    chk("sq_absdb_wr", {127'd0, reg_write_wb}, 128'd0);
    tick();
    chk("sq_avgb_wr", {127'd0, reg_write_wb}, 128'd1);
    chk("sq_avgb_addr", {121'd0, rt_addr_wb}, 128'd13);
    chk("sq_avgb_data", rt_wb, {16{8'h80}});
    clear_srcs();
    tick();

    // reset mid-stream with three live instructions in flight
    ra_even_addr = 8'd20; is_ra_even_valid = 1'b1;
    ra_odd_addr = 8'd22; is_ra_odd_valid = 1'b1;
    drive(OP_SUMB, 7'd20, {16{8'h11}}, {16{8'h22}}, 1'b1, 1'b0);
    tick();
    drive(OP_SUMB, 7'd21, {16{8'h33}}, {16{8'h44}}, 1'b1, 1'b0);
    tick();
    drive(OP_SUMB, 7'd22, {16{8'h55}}, {16{8'h66}}, 1'b1, 1'b0);
    tick();
    bubble();
    chk("prerst_wr", {127'd0, reg_write_wb}, 128'd1);
    chk("prerst_stall", {127'd0, stall_even_raw}, 128'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_data", rt_wb, 128'd0);
    chk("rst_mid_addr", {121'd0, rt_addr_wb}, 128'd0);
    chk("rst_mid_wr", {127'd0, reg_write_wb}, 128'd0);
    chk("rst_mid_se", {127'd0, stall_even_raw}, 128'd0);
    chk("rst_mid_so", {127'd0, stall_odd_raw}, 128'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_wr", {127'd0, reg_write_wb}, 128'd0);
    end
    clear_srcs();
    tick();

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simple_byte.md
Name: simple_byte

Overview:
- Byte-arithmetic execution unit of the SPU even pipeline.
- Executes the RR-format byte instructions cntb, avgb, absdb and sumb on 128-bit operands with a fixed 3-cycle latency.
- Its registered result feeds the even-pipe forwarding slot 4.
- Flags RAW hazards for both issue slots (even and odd) against its in-flight destinations.

Parameters:
- None. All widths are fixed by the SPU ISA.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- op  in  11 [0:10]  decoded opcode.
- format  in  3  instruction format; 0 = RR.
- rt_addr  in  7 [0:6]  destination register.
- ra, rb  in  128 [0:127] each  source operands; byte k = bits 8k..8k+7, byte 0 is most significant.
- imm  in  18 [0:17]  immediate; unused.
- reg_write  in  1  instruction writes the register file.
- branch_taken  in  1  squash the instruction being issued.
- ra_even_addr, rb_even_addr, rc_even_addr  in  8 [0:7] each  even-slot source addresses.
- ra_odd_addr, rb_odd_addr, rc_odd_addr  in  8 [0:7] each  odd-slot source addresses.
- is_ra_even_valid, is_rb_even_valid, is_rc_even_valid  in  1 each  even-slot source-used flags.
- is_ra_odd_valid, is_rb_odd_valid, is_rc_odd_valid  in  1 each  odd-slot source-used flags.
- rt_wb  out  128 [0:127]  result.
- rt_addr_wb  out  7  result destination.
- reg_write_wb  out  1  result valid / write enable.
- stall_even_raw  out  1  even-slot RAW hazard.
- stall_odd_raw  out  1  odd-slot RAW hazard.

Behaviour:
- Opcodes, all with format 0 (RR):
  - cntb = 11'b01010110100
  - avgb = 11'b00011010011
  - absdb = 11'b00001010011
  - sumb = 11'b01001010011
- Operations, per byte k = 0..15 unless stated:
  - cntb: rt byte k = popcount(ra byte k), range 0..8.
  - avgb: rt byte k = (ra_k + rb_k + 1) >> 1, computed in 9 bits with no overflow.
  - absdb: rt byte k = |rb_k − ra_k|, unsigned.
  - sumb, per word w = 0..3:
    - rt halfword 2w = zero-extended sum of the 4 bytes of rb word w.
    - rt halfword 2w+1 = the same sum over ra word w.
- Validity:
  - An instruction is live when reg_write=1, op/format match a listed opcode, and branch_taken=0.
  - Any other input is a bubble that enters the pipe with write=0, addr=0 and data=0.
- Pipeline:
  - Three register stages S1→S2→S3. Inputs are captured at rising edge N.
  - The result is computed combinationally in the first stage.
  - rt_wb, rt_addr_wb and reg_write_wb are the S3 registers, valid after edge N+2 (3-cycle latency).
  - Throughput is one instruction per cycle. No back-pressure; the unit never stalls itself.
- Reset:
  - Asserting reset asynchronously clears all stage registers: rt_wb=0, rt_addr_wb=0, reg_write_wb=0.
  - In-flight instructions are lost.
  - While reset=1, stall_even_raw=0 and stall_odd_raw=0.
- Hazard detection (combinational):
  - stall_even_raw = 1 when any even source x in {ra, rb, rc} has is_x_even_valid=1 and x_even_addr == {1'b0, stage_addr} for some stage S1, S2 or S3 whose write bit is 1.
  - stall_odd_raw is defined the same way for the odd sources.
  - Comparison is over 8 bits; an address with MSB 1 never matches.
  - The current-cycle input instruction is not included in the comparison.
- Boundaries:
  - Back-to-back writes to the same rt: both results emerge in order on consecutive cycles.
  - branch_taken squashes only the instruction presented in that cycle. Older in-flight instructions complete.

Test Plan:
1. Reset behaviour: assert reset mid-stream with 3 live instructions in flight → all outputs 0 immediately, both stall flags 0, no write emerges after release.
2. cntb: ra = 0xFF00_0F01 repeated ×4, rt_addr=5, reg_write=1.
   - Edges 1 and 2 after issue: reg_write_wb=0.
   - After the third edge: rt_wb = 0x0800_0401 ×4, rt_addr_wb=5, reg_write_wb=1, held for one cycle.
3. avgb and absdb: ra bytes = 0xFF, rb bytes = 0x01.
   - avgb → each byte 0x80.
   - absdb → each byte 0xFE.
   - Swapping ra and rb gives absdb 0xFE again.
4. sumb: ra bytes all 0xFF, rb bytes all 0x01 → each word 0x0004_03FC.
5. Hazard: issue cntb to rt=9, then set ra_even_addr=9 with is_ra_even_valid=1.
   - stall_even_raw=1 for exactly 3 cycles.
   - Clearing is_ra_even_valid drops the stall.
   - ra_odd_addr=9 raises stall_odd_raw.
   - Address 0x89 never matches.
6. Squash: issue absdb with branch_taken=1, followed by a live avgb → no write for absdb, avgb result appears on schedule, no stall raised for the absdb rt.
